// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async-FIFO read-side stream stage.
//   DEF_DATA_WIDTH : default width of FIFO / stream data
//   DEF_CNT_WIDTH  : default width of the delivered-word counter
//   CNT_EMPTY/ONE/TWO : occupancy encoding of the 2-entry output buffer
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

    // True while the output buffer can accept another FIFO word.
    function automatic logic buf_has_room(input logic [1:0] cnt);
        return (cnt != CNT_TWO);
    endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side consumer placed after an asynchronous FIFO. Turns the FIFO pop
// interface (rinc/rdata/rempty) into a registered valid/ready stream through a
// 2-entry buffer (head drives m_data, tail catches the word popped while the
// head is stalled). Because the buffer always has a spare slot when it pops,
// rinc depends only on registered occupancy and never on m_ready, yet one word
// per cycle is sustained.
//
// Ports
//   rclk      in   read-domain clock (rising edge)
//   rrst      in   asynchronous active-high reset
//   rempty    in   FIFO empty flag (synchronous to rclk)
//   rdata     in   FIFO head word, valid while rempty=0
//   rinc      out  FIFO pop request, effective at the next rclk edge
//   flush     in   synchronous discard of all buffered words
//   m_valid   out  stream word available (registered)
//   m_ready   in   downstream accepts the word
//   m_data    out  stream word (registered head of buffer)
//   word_cnt  out  number of delivered words, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic [1:0]            count_r;
    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic                  valid_r;
    logic [CNT_WIDTH-1:0]  word_cnt_r;

    logic [1:0]            count_nxt_s;
    logic [DATA_WIDTH-1:0] head_nxt_s;
    logic [DATA_WIDTH-1:0] tail_nxt_s;
    logic                  push_s;
    logic                  pop_s;

    // Pop request: registered occupancy plus inputs only. rrst is folded in so
    // the request drops the instant reset asserts, not one edge later.
    always_comb begin
        rinc = 1'b0;
        if (rrst) begin
            rinc = 1'b0;
        end else begin
            rinc = !rempty && buf_has_room(count_r) && !flush;
        end
    end

    assign push_s = rinc;
    assign pop_s  = valid_r && m_ready;

    // Buffer next-state: occupancy transitions and head/tail loading.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        if (flush) begin
            // rinc is already forced low, so only the drop of contents matters.
            count_nxt_s = CNT_EMPTY;
        end else begin
            case (count_r)
                CNT_EMPTY: begin
                    if (push_s) begin
                        head_nxt_s  = rdata;
                        count_nxt_s = CNT_ONE;
                    end else begin
                        count_nxt_s = CNT_EMPTY;
                    end
                end
                CNT_ONE: begin
                    if (push_s && pop_s) begin
                        head_nxt_s  = rdata;
                        count_nxt_s = CNT_ONE;
                    end else if (push_s) begin
                        // Head is stalled: it must not change until accepted.
                        tail_nxt_s  = rdata;
                        count_nxt_s = CNT_TWO;
                    end else if (pop_s) begin
                        count_nxt_s = CNT_EMPTY;
                    end else begin
                        count_nxt_s = CNT_ONE;
                    end
                end
                CNT_TWO: begin
                    if (pop_s) begin
                        head_nxt_s  = tail_r;
                        count_nxt_s = CNT_ONE;
                    end else begin
                        count_nxt_s = CNT_TWO;
                    end
                end
                default: begin
                    count_nxt_s = CNT_EMPTY;
                end
            endcase
        end
    end

    // Buffer state registers; m_valid is registered alongside the occupancy.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            count_r <= CNT_EMPTY;
            head_r  <= {DATA_WIDTH{1'b0}};
            tail_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            valid_r <= (count_nxt_s != CNT_EMPTY);
        end
    end

    // Delivered-word counter; a handshake in the flush cycle still counts.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            word_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (pop_s) begin
            word_cnt_r <= word_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign m_valid  = valid_r;
    assign m_data   = head_r;
    assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Self-checking bench: a queue models the FIFO contents, a scoreboard queue
// holds words popped from the FIFO that the stream has not yet delivered.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          rclk;
    logic          rrst;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_cnt;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .word_cnt (word_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_q[$];
    logic [CW-1:0] exp_cnt;
    logic          hide;
    logic          s_rinc;
    int            n_tests;
    int            n_fail;

    // One clock cycle: present FIFO state, check DUT against model, advance.
    // Entered and left at the falling edge of rclk.
    task automatic step();
        logic exp_rinc;
        rempty = hide || (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        #1;
        exp_rinc = !rempty && (sb_q.size() != 2) && !flush;
        n_tests++;
        if (rinc !== exp_rinc) begin
            n_fail++;
            $display("FAIL rinc t=%0t got=%b exp=%b", $time, rinc, exp_rinc);
        end
        n_tests++;
        if (m_valid !== (sb_q.size() != 0)) begin
            n_fail++;
            $display("FAIL m_valid t=%0t got=%b exp=%b", $time, m_valid, (sb_q.size() != 0));
        end
        n_tests++;
        if (word_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL word_cnt t=%0t got=%0d exp=%0d", $time, word_cnt, exp_cnt);
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            if (m_data !== sb_q[0]) begin
                n_fail++;
                $display("FAIL m_data t=%0t got=%h exp=%h", $time, m_data, sb_q[0]);
            end
        end
        s_rinc = rinc;
        if ((sb_q.size() != 0) && m_ready) begin
            void'(sb_q.pop_front());
            exp_cnt = exp_cnt + 4'd1;
        end
        if (flush) sb_q.delete();
        if (exp_rinc) sb_q.push_back(fifo_q.pop_front());
        @(posedge rclk);
        @(negedge rclk);
    endtask

    // Run cycles until FIFO model and scoreboard are empty, bounded.
    task automatic drain(input int budget);
        int k;
        k = 0;
        while (((fifo_q.size() != 0) || (sb_q.size() != 0)) && (k < budget)) begin
            step();
            k++;
        end
        n_tests++;
        if ((fifo_q.size() != 0) || (sb_q.size() != 0)) begin
            n_fail++;
            $display("FAIL drain_timeout fifo=%0d sb=%0d exp=0", fifo_q.size(), sb_q.size());
        end
    endtask

    // Short reset used to start a scenario from a known counter value.
    task automatic apply_reset();
        rrst = 1'b1;
        @(negedge rclk);
        rrst = 1'b0;
        fifo_q.delete();
        sb_q.delete();
        exp_cnt = 4'd0;
    endtask

    task automatic test_streaming();
        int nr, first, last;
        nr = 0; first = -1; last = -1;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_rinc) begin
                nr++;
                if (first < 0) first = i;
                last = i;
            end
        end
        n_tests++;
        if ((nr != 8) || (first != 0) || (last != 7)) begin
            n_fail++;
            $display("FAIL stream_rinc got n=%0d first=%0d last=%0d exp n=8 first=0 last=7", nr, first, last);
        end
        #1;
        n_tests++;
        if (word_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL stream_cnt got=%0d exp=8", word_cnt);
        end
    endtask

    task automatic test_backpressure();
        fifo_q.push_back(8'hA0);
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #1;
        n_tests++;
        if ((rinc !== 1'b0) || (m_data !== 8'hA0) || (m_valid !== 1'b1)) begin
            n_fail++;
            $display("FAIL bp_hold got rinc=%b m_data=%h m_valid=%b exp rinc=0 m_data=a0 m_valid=1",
                     rinc, m_data, m_valid);
        end
        m_ready = 1'b1;
        drain(20);
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < 200; i++) fifo_q.push_back(DW'($urandom_range(0, 255)));
        begin
            int k;
            k = 0;
            while (((fifo_q.size() != 0) || (sb_q.size() != 0)) && (k < 3000)) begin
                m_ready = ($urandom_range(0, 1) == 1);
                hide    = ($urandom_range(0, 3) == 0);
                step();
                k++;
            end
        end
        hide = 1'b0;
        m_ready = 1'b1;
        drain(20);
    endtask

    task automatic test_flush();
        logic [CW-1:0] cnt_before;
        fifo_q.push_back(8'h10);
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h12);
        fifo_q.push_back(8'h13);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        cnt_before = exp_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        n_tests++;
        if ((m_valid !== 1'b0) || (word_cnt !== cnt_before)) begin
            n_fail++;
            $display("FAIL flush_after got m_valid=%b cnt=%0d exp m_valid=0 cnt=%0d",
                     m_valid, word_cnt, cnt_before);
        end
        step();
        #1;
        n_tests++;
        if ((m_valid !== 1'b1) || (m_data !== 8'h12)) begin
            n_fail++;
            $display("FAIL flush_next got m_valid=%b m_data=%h exp m_valid=1 m_data=12", m_valid, m_data);
        end
        m_ready = 1'b1;
        drain(20);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h55 + DW'(i));
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #2;
        rrst = 1'b1;
        #1;
        n_tests++;
        if ((m_valid !== 1'b0) || (rinc !== 1'b0) || (m_data !== 8'h00) || (word_cnt !== 4'd0)) begin
            n_fail++;
            $display("FAIL reset_async got m_valid=%b rinc=%b m_data=%h cnt=%0d exp 0 0 00 0",
                     m_valid, rinc, m_data, word_cnt);
        end
        @(negedge rclk);
        rrst = 1'b0;
        fifo_q.delete();
        sb_q.delete();
        exp_cnt = 4'd0;
        m_ready = 1'b1;
        step();
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'hC0 + DW'(i));
        m_ready = 1'b1;
        drain(40);
        #1;
        n_tests++;
        if (word_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL cnt_wrap got=%0d exp=1", word_cnt);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 4'd0;
        hide    = 1'b0;
        s_rinc  = 1'b0;
        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        rempty  = 1'b1;
        rdata   = 8'h00;
        @(negedge rclk);
        #1;
        n_tests++;
        if ((m_valid !== 1'b0) || (rinc !== 1'b0) || (m_data !== 8'h00) || (word_cnt !== 4'd0)) begin
            n_fail++;
            $display("FAIL por_state got m_valid=%b rinc=%b m_data=%h cnt=%0d exp 0 0 00 0",
                     m_valid, rinc, m_data, word_cnt);
        end
        @(negedge rclk);
        rrst = 1'b0;
        test_streaming();
        test_backpressure();
        test_random_ready();
        test_flush();
        test_reset();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
